// File: rtl/vga_pkg.sv
// Shared cell codes, colour constants and default timing for the VGA pixel pipeline.
package vga_pkg;

    localparam int DEFAULT_ACTIVE_COLUMNS = 640;
    localparam int DEFAULT_ACTIVE_ROWS    = 480;
    localparam int DEFAULT_RAM_LATENCY    = 2;
    localparam int DEFAULT_CELL_WIDTH     = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SAND  = 2'd1,
        WALL  = 2'd2,
        WATER = 2'd3
    } cell_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_t;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    localparam rgb_t COLOUR_EMPTY = '{red: 4'h0, green: 4'h0, blue: 4'h0};
    localparam rgb_t COLOUR_SAND  = '{red: 4'hD, green: 4'hB, blue: 4'h5};
    localparam rgb_t COLOUR_WALL  = '{red: 4'h8, green: 4'h8, blue: 4'h8};
    localparam rgb_t COLOUR_WATER = '{red: 4'h2, green: 4'h5, blue: 4'hF};
    localparam rgb_t COLOUR_ERROR = '{red: 4'hF, green: 4'h0, blue: 4'hF};

    // Codes outside the defined cell set show as magenta so corrupt cells stand out on screen.
    function automatic rgb_t cell_colour(input logic [31:0] code);
        rgb_t colour;
        if (code > 32'd3) begin
            colour = COLOUR_ERROR;
        end else begin
            case (cell_t'(code[1:0]))
                EMPTY:   colour = COLOUR_EMPTY;
                SAND:    colour = COLOUR_SAND;
                WALL:    colour = COLOUR_WALL;
                WATER:   colour = COLOUR_WATER;
                default: colour = COLOUR_ERROR;
            endcase
        end
        return colour;
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH x WIDTH shift register with a configurable reset value, used to
// keep sync and enable timing aligned with the framebuffer read path.
module sync_delay_line #(
    parameter int               DEPTH       = 1,
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stages [DEPTH];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= RESET_VALUE;
            end
        end else begin
            stages[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign data_o = stages[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Framebuffer-to-VGA pixel pipeline: issues cell reads, maps cells to colour,
// delays syncs to match, and swaps display buffers only at frame boundaries.
module vga_pixel_pipeline
    import vga_pkg::*;
#(
    parameter int  ACTIVE_COLUMNS = DEFAULT_ACTIVE_COLUMNS,
    parameter int  ACTIVE_ROWS    = DEFAULT_ACTIVE_ROWS,
    parameter int  RAM_LATENCY    = DEFAULT_RAM_LATENCY,
    parameter int  CELL_WIDTH     = DEFAULT_CELL_WIDTH,
    localparam int PW             = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS)
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  hsync_i,
    input  logic                  vsync_i,
    input  logic                  video_en_i,
    input  logic [PW-1:0]         pixel_i,
    output logic                  rd_en_o,
    output logic [PW:0]           rd_addr_o,
    input  logic [CELL_WIDTH-1:0] rd_data_i,
    input  logic                  swap_req_i,
    output logic                  swap_ack_o,
    output logic                  buffer_sel_o,
    output logic                  frame_done_o,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic [3:0]            red_o,
    output logic [3:0]            green_o,
    output logic [3:0]            blue_o
);

    localparam int            TOTAL_LATENCY = RAM_LATENCY + 2;
    localparam logic [PW-1:0] LAST_PIXEL    = PW'(ACTIVE_COLUMNS * ACTIVE_ROWS - 1);

    swap_state_t swap_state;
    logic        end_of_frame;
    logic [2:0]  timing_d;
    rgb_t        colour;

    assign end_of_frame = video_en_i && (pixel_i == LAST_PIXEL);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
        end else begin
            rd_en_o   <= video_en_i;
            rd_addr_o <= {buffer_sel_o, pixel_i};
        end
    end

    // The buffer bit flips together with frame_done_o, so every address of a frame carries one buffer.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            swap_state   <= IDLE;
            buffer_sel_o <= 1'b0;
            swap_ack_o   <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= end_of_frame;
            swap_ack_o   <= 1'b0;
            case (swap_state)
                IDLE: begin
                    if (swap_req_i) begin
                        if (end_of_frame) begin
                            buffer_sel_o <= ~buffer_sel_o;
                            swap_ack_o   <= 1'b1;
                        end else begin
                            swap_state <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (end_of_frame) begin
                        buffer_sel_o <= ~buffer_sel_o;
                        swap_ack_o   <= 1'b1;
                        swap_state   <= IDLE;
                    end
                end
                default: swap_state <= IDLE;
            endcase
        end
    end

    // One stage short of the full latency: the colour register below supplies the last stage.
    sync_delay_line #(
        .DEPTH       (TOTAL_LATENCY - 1),
        .WIDTH       (3),
        .RESET_VALUE (3'b110)
    ) u_timing_delay (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  ({hsync_i, vsync_i, video_en_i}),
        .data_o  (timing_d)
    );

    assign colour = timing_d[0] ? cell_colour(32'(rd_data_i)) : COLOUR_EMPTY;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hsync_o <= 1'b1;
            vsync_o <= 1'b1;
            red_o   <= 4'h0;
            green_o <= 4'h0;
            blue_o  <= 4'h0;
        end else begin
            hsync_o <= timing_d[2];
            vsync_o <= timing_d[1];
            red_o   <= colour.red;
            green_o <= colour.green;
            blue_o  <= colour.blue;
        end
    end

endmodule

// File: tb/tb_vga_pixel_pipeline.sv
// Bench for vga_pixel_pipeline: a default-sized instance plus a small one with
// 1-cycle RAM and 3-bit cells, both checked every cycle against a cycle-history model.
`timescale 1ns/1ps
module tb_vga_pixel_pipeline;

    localparam int LAST_A = 307199;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        hsync_i = 1'b1;
    logic        vsync_i = 1'b1;
    logic        video_en_i = 1'b0;
    logic        swap_req_i = 1'b0;
    logic [18:0] pixel_a = '0;
    logic [4:0]  pixel_b = '0;
    logic [1:0]  rd_data_a = '0;
    logic [2:0]  rd_data_b = '0;

    logic        rd_en_a, swap_ack_a, buffer_sel_a, frame_done_a, hsync_a, vsync_a;
    logic [19:0] rd_addr_a;
    logic [3:0]  red_a, green_a, blue_a;
    logic        rd_en_b, swap_ack_b, buffer_sel_b, frame_done_b, hsync_b, vsync_b;
    logic [5:0]  rd_addr_b;
    logic [3:0]  red_b, green_b, blue_b;

    int vectors = 0;
    int miscompares = 0;
    int force_cell = -1;

    typedef struct {
        bit hs;
        bit vs;
        bit en;
        bit sel;
        int pix;
    } rec_t;

    rec_t hist [2][8];
    int   cyc [2];
    bit   m_sel [2];
    bit   m_pend [2];
    bit   m_fd [2];
    bit   m_ack [2];

    always #5 clk = ~clk;

    vga_pixel_pipeline dut_a (
        .clk_i(clk), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .video_en_i(video_en_i), .pixel_i(pixel_a), .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a),
        .rd_data_i(rd_data_a), .swap_req_i(swap_req_i), .swap_ack_o(swap_ack_a),
        .buffer_sel_o(buffer_sel_a), .frame_done_o(frame_done_a), .hsync_o(hsync_a),
        .vsync_o(vsync_a), .red_o(red_a), .green_o(green_a), .blue_o(blue_a)
    );

    vga_pixel_pipeline #(
        .ACTIVE_COLUMNS(8), .ACTIVE_ROWS(4), .RAM_LATENCY(1), .CELL_WIDTH(3)
    ) dut_b (
        .clk_i(clk), .reset_i(reset_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
        .video_en_i(video_en_i), .pixel_i(pixel_b), .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b),
        .rd_data_i(rd_data_b), .swap_req_i(swap_req_i), .swap_ack_o(swap_ack_b),
        .buffer_sel_o(buffer_sel_b), .frame_done_o(frame_done_b), .hsync_o(hsync_b),
        .vsync_o(vsync_b), .red_o(red_b), .green_o(green_b), .blue_o(blue_b)
    );

    function automatic int cell_of(input int d, input int addr);
        int w = (d == 0) ? 2 : 3;
        return (addr ^ (addr >> 3)) & ((1 << w) - 1);
    endfunction

    function automatic logic [11:0] colour_ref(input int code);
        case (code)
            0:       return 12'h000;
            1:       return 12'hDB5;
            2:       return 12'h888;
            3:       return 12'h25F;
            default: return 12'hF0F;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit en, input bit hs, input bit vs,
                                 input int pix, input bit req);
        @(posedge clk);
        #1;
        reset_i    = rst;
        video_en_i = en;
        hsync_i    = hs;
        vsync_i    = vs;
        pixel_a    = 19'(pix);
        pixel_b    = 5'(pix % 32);
        swap_req_i = req;
    endtask

    task automatic wipe_history(input int d);
        for (int i = 0; i < 8; i++) hist[d][i] = '{hs: 1'b1, vs: 1'b1, en: 1'b0, sel: 1'b0, pix: 0};
    endtask

    task automatic compare_dut(input int d, input logic rst, input bit hs_i, input bit vs_i,
                               input bit en_i, input int pix_i, input bit req_i,
                               input logic rd_en, input logic [31:0] rd_addr, input logic [11:0] rgb,
                               input logic hs_o, input logic vs_o, input logic fd,
                               input logic ack, input logic sel);
        string pre  = (d == 0) ? "A " : "B ";
        int    lat  = (d == 0) ? 4 : 3;
        int    pw   = (d == 0) ? 19 : 5;
        int    last = (d == 0) ? LAST_A : 31;
        rec_t  p, q;
        bit    eof;
        if (rst === 1'b1) begin
            checkOutput({pre, "reset rd_en"}, 32'(rd_en), 0);
            checkOutput({pre, "reset rd_addr"}, rd_addr, 0);
            checkOutput({pre, "reset rgb"}, 32'(rgb), 0);
            checkOutput({pre, "reset syncs"}, {30'd0, hs_o, vs_o}, 3);
            checkOutput({pre, "reset fd/ack/sel"}, {29'd0, fd, ack, sel}, 0);
            wipe_history(d);
            m_sel[d]  = 1'b0;
            m_pend[d] = 1'b0;
            m_fd[d]   = 1'b0;
            m_ack[d]  = 1'b0;
        end else begin
            p = hist[d][(cyc[d] - 1) & 7];
            q = hist[d][(cyc[d] - lat) & 7];
            checkOutput({pre, "rd_en"}, 32'(rd_en), 32'(p.en));
            if (p.en) checkOutput({pre, "rd_addr"}, rd_addr, (32'(p.sel) << pw) | 32'(p.pix));
            checkOutput({pre, "hsync_o"}, 32'(hs_o), 32'(q.hs));
            checkOutput({pre, "vsync_o"}, 32'(vs_o), 32'(q.vs));
            checkOutput({pre, "rgb"}, 32'(rgb),
                        q.en ? 32'(colour_ref(cell_of(d, (int'(q.sel) << pw) | q.pix))) : 0);
            checkOutput({pre, "frame_done"}, 32'(fd), 32'(m_fd[d]));
            checkOutput({pre, "swap_ack"}, 32'(ack), 32'(m_ack[d]));
            checkOutput({pre, "buffer_sel"}, 32'(sel), 32'(m_sel[d]));
            hist[d][cyc[d] & 7] = '{hs: hs_i, vs: vs_i, en: en_i, sel: m_sel[d], pix: pix_i};
            eof      = en_i && (pix_i == last);
            m_fd[d]  = eof;
            m_ack[d] = 1'b0;
            if (eof && (m_pend[d] || req_i)) begin
                m_sel[d]  = ~m_sel[d];
                m_ack[d]  = 1'b1;
                m_pend[d] = 1'b0;
            end else if (req_i) begin
                m_pend[d] = 1'b1;
            end
        end
        cyc[d]++;
    endtask

    // Framebuffer stand-in: returns the cell for the address issued RAM_LATENCY cycles earlier.
    initial begin
        int addr_a [4];
        int addr_b [4];
        for (int i = 0; i < 4; i++) begin
            addr_a[i] = 0;
            addr_b[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 3; i > 0; i--) begin
                addr_a[i] = addr_a[i-1];
                addr_b[i] = addr_b[i-1];
            end
            addr_a[0] = int'(rd_addr_a);
            addr_b[0] = int'(rd_addr_b);
            rd_data_a = (force_cell >= 0) ? 2'(force_cell) : 2'(cell_of(0, addr_a[2]));
            rd_data_b = (force_cell >= 0) ? 3'(force_cell) : 3'(cell_of(1, addr_b[1]));
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            wipe_history(d);
            cyc[d] = 8;
        end
        forever begin
            @(negedge clk);
            compare_dut(0, reset_i, hsync_i, vsync_i, video_en_i, int'(pixel_a), swap_req_i,
                        rd_en_a, 32'(rd_addr_a), {red_a, green_a, blue_a},
                        hsync_a, vsync_a, frame_done_a, swap_ack_a, buffer_sel_a);
            compare_dut(1, reset_i, hsync_i, vsync_i, video_en_i, int'(pixel_b), swap_req_i,
                        rd_en_b, 32'(rd_addr_b), {red_b, green_b, blue_b},
                        hsync_b, vsync_b, frame_done_b, swap_ack_b, buffer_sel_b);
        end
    end

    initial begin
        int first_low;
        int low_count;
        int acks;
        bit rgb_seen;

        // Reset held for three clocks.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("s1 hsync/vsync", {30'd0, hsync_a, vsync_a}, 3);
        checkOutput("s1 rgb", 32'({red_a, green_a, blue_a}), 0);
        checkOutput("s1 buffer_sel", 32'(buffer_sel_a), 0);
        checkOutput("s1 rd_en", 32'(rd_en_a), 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        repeat (3) applyStimulus(0, 0, 1, 1, 0, 0);

        // Pixel 5 holds sand: address after one clock, colour after four.
        applyStimulus(0, 1, 1, 1, 5, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("s2 rd_en", 32'(rd_en_a), 1);
        checkOutput("s2 rd_addr", 32'(rd_addr_a), 5);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("s2 rgb early", 32'({red_a, green_a, blue_a}), 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("s2 rgb sand", 32'({red_a, green_a, blue_a}), 32'h0DB5);
        repeat (2) applyStimulus(0, 0, 1, 1, 0, 0);

        // Blanking with water on the data bus and a 96-clock hsync pulse.
        force_cell = 3;
        first_low  = -1;
        low_count  = 0;
        rgb_seen   = 1'b0;
        for (int k = 0; k < 110; k++) begin
            applyStimulus(0, 0, (k < 96) ? 1'b0 : 1'b1, 1, k, 0);
            @(negedge clk);
            if (hsync_a == 1'b0) begin
                low_count++;
                if (first_low < 0) first_low = k;
            end
            if ({red_a, green_a, blue_a} != 12'h000) rgb_seen = 1'b1;
        end
        force_cell = -1;
        checkOutput("s3 hsync delay", 32'(first_low), 4);
        checkOutput("s3 hsync width", 32'(low_count), 96);
        checkOutput("s3 blank rgb", 32'(rgb_seen), 0);

        // Mid-frame swap request waits for the end of the frame.
        applyStimulus(0, 1, 1, 1, 1000, 0);
        applyStimulus(0, 1, 1, 1, 1001, 1);
        for (int p = 1002; p < 1010; p++) applyStimulus(0, 1, 1, 1, p, 0);
        @(negedge clk);
        checkOutput("s4 sel mid-frame", 32'(buffer_sel_a), 0);
        applyStimulus(0, 1, 1, 1, LAST_A, 0);
        @(negedge clk);
        checkOutput("s4 sel at last pixel", {30'd0, frame_done_a, buffer_sel_a}, 0);
        applyStimulus(0, 1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("s4 done/ack/sel", {29'd0, frame_done_a, swap_ack_a, buffer_sel_a}, 7);
        applyStimulus(0, 1, 1, 1, 1, 0);
        @(negedge clk);
        checkOutput("s4 next frame addr", 32'(rd_addr_a), 32'h80000);
        checkOutput("s4 ack single", 32'(swap_ack_a), 0);

        // Request coinciding with the last pixel, then two requests coalescing.
        applyStimulus(0, 1, 1, 1, LAST_A, 1);
        applyStimulus(0, 1, 1, 1, 0, 0);
        @(negedge clk);
        checkOutput("s5 simultaneous ack/sel", {30'd0, swap_ack_a, buffer_sel_a}, 2);
        acks = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(0, 1, 1, 1, (k == 25) ? LAST_A : 100 + k, (k == 5) || (k == 12));
            @(negedge clk);
            acks += int'(swap_ack_a);
        end
        checkOutput("s5 coalesced acks", 32'(acks), 1);
        checkOutput("s5 coalesced sel", 32'(buffer_sel_a), 1);

        // Reset while a swap is pending discards it.
        applyStimulus(0, 1, 1, 1, 999, 1);
        applyStimulus(0, 1, 1, 1, 1000, 0);
        #2 reset_i = 1'b1;
        @(negedge clk);
        checkOutput("s6 sel in reset", 32'(buffer_sel_a), 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 1, 1, 1, (k == 5) ? LAST_A : 2000 + k, 0);
            @(negedge clk);
            acks += int'(swap_ack_a);
        end
        checkOutput("s6 no ack after reset", 32'(acks), 0);
        checkOutput("s6 sel after reset", 32'(buffer_sel_a), 0);

        // Randomised traffic with occasional resets, swaps and end-of-frame pixels.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus($urandom_range(0, 499) == 0,
                          $urandom_range(0, 7) != 0,
                          $urandom_range(0, 15) != 0,
                          $urandom_range(0, 15) != 0,
                          ($urandom_range(0, 99) == 0) ? LAST_A : int'($urandom_range(0, LAST_A)),
                          $urandom_range(0, 29) == 0);
        end
        repeat (6) applyStimulus(0, 0, 1, 1, 0, 0);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
